// File: rtl/wormhole_output_arbiter.sv
// Per-output-port wormhole arbiter: round-robin packet grants, lock until TAIL,
// per-VC on/off backpressure and a registered output flit.
package noc_params;
  localparam int PORT_NUM = 10;
  localparam int VC_NUM   = 2;
  localparam int VC_W     = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
  localparam int DATA_W   = 16;

  typedef enum logic [1:0] {
    HEAD     = 2'b00,
    BODY     = 2'b01,
    TAIL     = 2'b10,
    HEADTAIL = 2'b11
  } flit_label_t;

  typedef struct packed {
    flit_label_t       flit_label;
    logic [VC_W-1:0]   vc_id;
    logic [DATA_W-1:0] data;
  } flit_t;
endpackage

module wormhole_output_arbiter
  import noc_params::*;
#(
  parameter int N_IN  = PORT_NUM,
  parameter int IDX_W = $clog2(N_IN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IN-1:0]  req_i,
  input  flit_t            flit_i [N_IN],
  output logic [N_IN-1:0]  ack_o,
  input  logic [VC_NUM-1:0] on_off_i,
  output flit_t            out_flit_o,
  output logic             out_valid_o,
  output logic             locked_o,
  output logic [IDX_W-1:0] owner_o,
  output logic             proto_err_o
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_rr_ptr;
  logic [IDX_W-1:0] r_owner;
  logic [VC_W-1:0]  r_locked_vc;
  logic             r_locked;
  flit_t            r_out_flit;
  logic             r_out_valid;
  logic             r_proto_err;

  logic [N_IN-1:0]  w_head;
  logic [N_IN-1:0]  w_elig;
  logic [N_IN-1:0]  w_bad;
  logic [IDX_W:0]   w_pick;
  logic             w_found;
  logic [IDX_W-1:0] w_win;
  flit_t            w_win_flit;
  flit_t            w_own_flit;
  logic             w_own_head;
  logic             w_own_fwd;

  function automatic logic is_head(input flit_label_t lab);
    return (lab == HEAD) || (lab == HEADTAIL);
  endfunction

  // Explicit compare keeps the wrap correct for non-power-of-two N_IN.
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(N_IN - 1)) ? '0 : idx + IDX_W'(1);
  endfunction

  // Returns {found, index}; scanning offsets high to low lets the smallest offset win.
  function automatic logic [IDX_W:0] rr_pick(input logic [N_IN-1:0] elig,
                                             input logic [IDX_W-1:0] ptr);
    logic [IDX_W:0] pos;
    logic [IDX_W:0] res;
    res = '0;
    for (int k = N_IN - 1; k >= 0; k--) begin
      pos = {1'b0, ptr} + (IDX_W + 1)'(k);
      if (pos >= (IDX_W + 1)'(N_IN)) begin
        pos = pos - (IDX_W + 1)'(N_IN);
      end else begin
        pos = pos;
      end
      if (elig[pos[IDX_W-1:0]]) begin
        res = {1'b1, pos[IDX_W-1:0]};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Classify requesters and resolve the candidate winner.
  always_comb begin
    w_head = '0;
    w_elig = '0;
    w_bad  = '0;
    for (int i = 0; i < N_IN; i++) begin
      w_head[i] = is_head(flit_i[i].flit_label);
      w_elig[i] = req_i[i] & w_head[i] & on_off_i[flit_i[i].vc_id];
      w_bad[i]  = req_i[i] & ~w_head[i];
    end
    w_pick     = rr_pick(w_elig, r_rr_ptr);
    w_found    = w_pick[IDX_W];
    w_win      = w_pick[IDX_W-1:0];
    w_win_flit = flit_i[w_win];
    w_own_flit = flit_i[r_owner];
    w_own_head = is_head(w_own_flit.flit_label);
    w_own_fwd  = req_i[r_owner] & on_off_i[r_locked_vc] & ~w_own_head;
  end

  // Combinational one-hot acknowledge.
  always_comb begin
    ack_o = '0;
    if (rst) begin
      ack_o = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            ack_o[w_win] = 1'b1;
          end else begin
            ack_o = '0;
          end
        end
        ST_LOCKED: begin
          if (w_own_fwd) begin
            ack_o[r_owner] = 1'b1;
          end else begin
            ack_o = '0;
          end
        end
        default: ack_o = '0;
      endcase
    end
  end

  // Arbitration FSM with registered link outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= '0;
      r_owner     <= '0;
      r_locked_vc <= '0;
      r_locked    <= 1'b0;
      r_out_flit  <= '0;
      r_out_valid <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_proto_err <= |w_bad & ~w_found;
          if (w_found) begin
            r_out_flit  <= w_win_flit;
            r_out_valid <= 1'b1;
            if (w_win_flit.flit_label == HEAD) begin
              r_state     <= ST_LOCKED;
              r_locked    <= 1'b1;
              r_owner     <= w_win;
              r_locked_vc <= w_win_flit.vc_id;
            end else begin
              r_rr_ptr <= wrap_inc(w_win);
            end
          end else begin
            r_out_valid <= 1'b0;
          end
        end
        ST_LOCKED: begin
          r_proto_err <= req_i[r_owner] & w_own_head;
          if (w_own_fwd) begin
            r_out_flit  <= w_own_flit;
            r_out_valid <= 1'b1;
            if (w_own_flit.flit_label == TAIL) begin
              r_state  <= ST_IDLE;
              r_locked <= 1'b0;
              r_rr_ptr <= wrap_inc(r_owner);
            end else begin
              r_state <= ST_LOCKED;
            end
          end else begin
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_locked    <= 1'b0;
          r_out_valid <= 1'b0;
          r_proto_err <= 1'b0;
        end
      endcase
    end
  end

  assign out_flit_o  = r_out_flit;
  assign out_valid_o = r_out_valid;
  assign locked_o    = r_locked;
  assign owner_o     = r_owner;
  assign proto_err_o = r_proto_err;

endmodule

// File: tb/tb_wormhole_output_arbiter.sv
// Bench for wormhole_output_arbiter: directed vector table, hand sequences, and
// randomized traffic against a distance-based round-robin reference model.
module tb_wormhole_output_arbiter;
  import noc_params::*;

  localparam int N = 10;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req_s;
  flit_t          flit_s [N];
  logic [N-1:0]   ack_s;
  logic [VC_NUM-1:0] on_off_s;
  flit_t          out_flit_s;
  logic           out_valid_s;
  logic           locked_s;
  logic [3:0]     owner_s;
  logic           proto_err_s;

  wormhole_output_arbiter #(.N_IN(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req_s),
    .flit_i      (flit_s),
    .ack_o       (ack_s),
    .on_off_i    (on_off_s),
    .out_flit_o  (out_flit_s),
    .out_valid_o (out_valid_s),
    .locked_o    (locked_s),
    .owner_o     (owner_s),
    .proto_err_o (proto_err_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic         m_locked;
  int           m_owner;
  logic         m_vc;
  int           m_rr;
  int           m_win;
  logic         m_fwd;
  logic [N-1:0] m_ack;
  logic         e_valid;
  flit_t        e_flit;
  logic         e_err;
  logic         flit_chk;
  logic [N-1:0] cap_ack;

  typedef struct {
    logic        rst;
    int          src;
    flit_label_t lab;
    logic        vc;
    logic [1:0]  onoff;
    logic [N-1:0] ack;
    logic        valid;
    logic        locked;
    logic        err;
  } vec_t;

  vec_t tbl [21];

  function automatic logic is_hd(input flit_label_t l);
    return (l == HEAD) || (l == HEADTAIL);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_comb();
    int bestd;
    int d;
    m_win = -1;
    bestd = N;
    m_ack = '0;
    m_fwd = 1'b0;
    if (rst) begin
      m_ack = '0;
    end else if (!m_locked) begin
      for (int i = 0; i < N; i++) begin
        if (req_s[i] && is_hd(flit_s[i].flit_label) && on_off_s[flit_s[i].vc_id]) begin
          d = (i - m_rr + N) % N;
          if (d < bestd) begin
            bestd = d;
            m_win = i;
          end
        end
      end
      if (m_win >= 0) m_ack[m_win] = 1'b1;
    end else begin
      if (req_s[m_owner] && !is_hd(flit_s[m_owner].flit_label) && on_off_s[m_vc]) begin
        m_fwd = 1'b1;
        m_ack[m_owner] = 1'b1;
      end
    end
  endtask

  task automatic model_next();
    logic any_bad;
    any_bad = 1'b0;
    for (int i = 0; i < N; i++)
      if (req_s[i] && !is_hd(flit_s[i].flit_label)) any_bad = 1'b1;
    if (rst) begin
      m_locked = 1'b0; m_owner = 0; m_vc = 1'b0; m_rr = 0;
      e_valid = 1'b0; e_flit = '0; e_err = 1'b0; flit_chk = 1'b1;
    end else if (!m_locked) begin
      if (m_win >= 0) begin
        e_valid = 1'b1; e_flit = flit_s[m_win]; flit_chk = 1'b1; e_err = 1'b0;
        if (flit_s[m_win].flit_label == HEAD) begin
          m_locked = 1'b1; m_owner = m_win; m_vc = flit_s[m_win].vc_id;
        end else begin
          m_rr = (m_win + 1) % N;
        end
      end else begin
        e_valid = 1'b0; flit_chk = 1'b0; e_err = any_bad;
      end
    end else begin
      if (m_fwd) begin
        e_valid = 1'b1; e_flit = flit_s[m_owner]; flit_chk = 1'b1; e_err = 1'b0;
        if (flit_s[m_owner].flit_label == TAIL) begin
          m_locked = 1'b0; m_rr = (m_owner + 1) % N;
        end
      end else begin
        e_valid = 1'b0; flit_chk = 1'b0;
        e_err = req_s[m_owner] && is_hd(flit_s[m_owner].flit_label);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_comb();
    cap_ack = ack_s;
    chk("ack", 64'(ack_s), 64'(m_ack));
    chk("out_valid", 64'(out_valid_s), 64'(e_valid));
    if (flit_chk) chk("out_flit", 64'(out_flit_s), 64'(e_flit));
    chk("locked", 64'(locked_s), 64'(m_locked));
    if (m_locked) chk("owner", 64'(owner_s), 64'(m_owner));
    chk("proto_err", 64'(proto_err_s), 64'(e_err));
    model_next();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req_s = '0;
    for (int i = 0; i < N; i++) flit_s[i] = '{BODY, 1'b0, 16'h0000};
  endtask

  task automatic present(input int src, input flit_label_t lab, input logic vc);
    req_s[src] = 1'b1;
    flit_s[src] = '{lab, vc, 16'(src * 256 + $urandom_range(0, 255))};
  endtask

  initial begin
    tbl[0]  = '{1'b0,  3, HEAD,     1'b1, 2'b11, 10'h008, 1'b1, 1'b1, 1'b0};
    tbl[1]  = '{1'b0,  3, BODY,     1'b1, 2'b11, 10'h008, 1'b1, 1'b1, 1'b0};
    tbl[2]  = '{1'b0,  3, TAIL,     1'b1, 2'b11, 10'h008, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, -1, BODY,     1'b0, 2'b11, 10'h000, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0,  6, BODY,     1'b0, 2'b11, 10'h000, 1'b0, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, -1, BODY,     1'b0, 2'b11, 10'h000, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0,  4, HEAD,     1'b0, 2'b11, 10'h010, 1'b1, 1'b1, 1'b0};
    tbl[7]  = '{1'b0,  4, BODY,     1'b0, 2'b01, 10'h010, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{1'b0,  4, BODY,     1'b0, 2'b00, 10'h000, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{1'b0,  4, BODY,     1'b0, 2'b10, 10'h000, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{1'b0,  4, BODY,     1'b0, 2'b00, 10'h000, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{1'b0,  4, BODY,     1'b0, 2'b10, 10'h000, 1'b0, 1'b1, 1'b0};
    tbl[12] = '{1'b0,  4, BODY,     1'b0, 2'b00, 10'h000, 1'b0, 1'b1, 1'b0};
    tbl[13] = '{1'b0,  4, BODY,     1'b0, 2'b01, 10'h010, 1'b1, 1'b1, 1'b0};
    tbl[14] = '{1'b0,  4, TAIL,     1'b0, 2'b11, 10'h010, 1'b1, 1'b0, 1'b0};
    tbl[15] = '{1'b0,  1, HEAD,     1'b0, 2'b11, 10'h002, 1'b1, 1'b1, 1'b0};
    tbl[16] = '{1'b0,  1, BODY,     1'b0, 2'b11, 10'h002, 1'b1, 1'b1, 1'b0};
    tbl[17] = '{1'b0,  1, HEAD,     1'b0, 2'b11, 10'h000, 1'b0, 1'b1, 1'b1};
    tbl[18] = '{1'b1,  1, BODY,     1'b0, 2'b11, 10'h000, 1'b0, 1'b0, 1'b0};
    tbl[19] = '{1'b0,  8, HEAD,     1'b1, 2'b11, 10'h100, 1'b1, 1'b1, 1'b0};
    tbl[20] = '{1'b0,  8, TAIL,     1'b1, 2'b11, 10'h100, 1'b1, 1'b0, 1'b0};

    m_locked = 1'b0; m_owner = 0; m_vc = 1'b0; m_rr = 0;
    e_valid = 1'b0; e_flit = '0; e_err = 1'b0; flit_chk = 1'b1;
    rst = 1'b1;
    on_off_s = 2'b11;
    clear_inputs();
    @(posedge clk);
    #1;

    // Directed vector table
    for (int r = 0; r < 21; r++) begin
      rst = tbl[r].rst;
      on_off_s = tbl[r].onoff;
      clear_inputs();
      if (tbl[r].src >= 0) present(tbl[r].src, tbl[r].lab, tbl[r].vc);
      tick();
      chk($sformatf("tbl%0d_ack", r), 64'(cap_ack), 64'(tbl[r].ack));
      chk($sformatf("tbl%0d_valid", r), 64'(out_valid_s), 64'(tbl[r].valid));
      chk($sformatf("tbl%0d_locked", r), 64'(locked_s), 64'(tbl[r].locked));
      chk($sformatf("tbl%0d_err", r), 64'(proto_err_s), 64'(tbl[r].err));
      if (r == 2)  chk("rr_after_tail", 64'(dut.r_rr_ptr), 64'd4);
      if (r == 18) chk("rr_after_rst", 64'(dut.r_rr_ptr), 64'd0);
    end

    // Round-robin among three continuous HEADTAIL requesters
    begin
      int ord [6] = '{0, 5, 9, 0, 5, 9};
      rst = 1'b1; clear_inputs(); tick();
      rst = 1'b0; on_off_s = 2'b11;
      for (int k = 0; k < 6; k++) begin
        clear_inputs();
        present(0, HEADTAIL, 1'b0);
        present(5, HEADTAIL, 1'b1);
        present(9, HEADTAIL, 1'b0);
        tick();
        chk("rr_order", 64'(cap_ack), 64'(10'b1 << ord[k]));
        if (k == 2) chk("rr_wrap", 64'(dut.r_rr_ptr), 64'd0);
      end
    end

    // Wormhole lock: requester 7 waits for requester 2's TAIL
    rst = 1'b1; clear_inputs(); tick();
    rst = 1'b0;
    clear_inputs(); present(2, HEAD, 1'b0); present(7, HEAD, 1'b1); tick();
    chk("lock_head", 64'(cap_ack), 64'(10'h004));
    clear_inputs(); present(2, BODY, 1'b0); present(7, HEAD, 1'b1); tick();
    chk("lock_body", 64'(cap_ack), 64'(10'h004));
    clear_inputs(); present(2, TAIL, 1'b0); present(7, HEAD, 1'b1); tick();
    chk("lock_tail", 64'(cap_ack), 64'(10'h004));
    clear_inputs(); present(7, HEAD, 1'b1); tick();
    chk("lock_next_head", 64'(cap_ack), 64'(10'h080));
    clear_inputs(); present(7, TAIL, 1'b1); tick();
    chk("lock_next_tail", 64'(cap_ack), 64'(10'h080));

    // Randomized traffic checked by the reference model inside tick()
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 79) == 0);
      on_off_s = 2'($urandom_range(0, 3));
      for (int i = 0; i < N; i++) begin
        req_s[i] = ($urandom_range(0, 2) != 0);
        flit_s[i] = '{flit_label_t'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      16'($urandom_range(0, 65535))};
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
